// File: rtl/servo_pkg.sv
// servo_pkg: shared constants, types and angle clamp for the servo PWM block.
package servo_pkg;
    localparam int ANGLE_MAX      = 180;
    localparam int ANGLE_RESET    = 90;
    localparam int DEF_PERIOD_CYC = 1_000_000;
    localparam int DEF_MIN_CYC    = 50_000;
    localparam int DEF_STEP_CYC   = 278;

    typedef logic [7:0]  angle_t;
    typedef logic [16:0] width_t;
    typedef logic [19:0] cnt_t;

    function automatic angle_t clamp_angle(input angle_t a);
        return (a > angle_t'(ANGLE_MAX)) ? angle_t'(ANGLE_MAX) : a;
    endfunction
endpackage

// File: rtl/servo_channel.sv
// servo_channel: one channel's shadow, clamp, slew, width and pulse compare.
// SERVO_SOFTSTART_EN limits the applied angle to 1 degree of movement per frame.
module servo_channel
    import servo_pkg::*;
#(
    parameter int MIN_CYC  = DEF_MIN_CYC,
    parameter int STEP_CYC = DEF_STEP_CYC
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   sample_i,
    input  angle_t angle_i,
    input  logic   en_i,
    input  cnt_t   cnt_i,
    output logic   pwm_o,
    output logic   clamp_o
);
    angle_t tgt, ang_d, ang_q;
    width_t width_q;
    logic   en_q, clamp_q, pwm_q;

    assign tgt = clamp_angle(angle_i);
`ifdef SERVO_SOFTSTART_EN
    assign ang_d = (tgt > ang_q) ? ang_q + 8'd1 : (tgt < ang_q) ? ang_q - 8'd1 : ang_q;
`else
    assign ang_d = tgt;
`endif

    // Width settles one cycle after sampling, so the pulse starts at cnt=1 -> rises 2 cycles after frame_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q    <= 1'b0;
            clamp_q <= 1'b0;
            ang_q   <= angle_t'(ANGLE_RESET);
            width_q <= width_t'(MIN_CYC + ANGLE_RESET * STEP_CYC);
            pwm_q   <= 1'b0;
        end else begin
            if (sample_i) begin
                en_q    <= en_i;
                clamp_q <= angle_i > angle_t'(ANGLE_MAX);
                ang_q   <= ang_d;
            end
            width_q <= width_t'(MIN_CYC + int'(ang_q) * STEP_CYC);
            pwm_q   <= en_q && cnt_i != '0 && cnt_i <= cnt_t'(width_q);
        end
    end

    assign pwm_o   = pwm_q;
    assign clamp_o = clamp_q;
endmodule

// File: rtl/servo_pwm.sv
// servo_pwm: four-channel servo PWM generator sharing one frame counter.
// SERVO_SOFTSTART_EN enables per-frame angle slew inside each channel.
module servo_pwm
    import servo_pkg::*;
#(
    parameter int PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int MIN_CYC    = DEF_MIN_CYC,
    parameter int STEP_CYC   = DEF_STEP_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] angle1,
    input  logic [7:0] angle2,
    input  logic [7:0] angle3,
    input  logic [7:0] angle4,
    input  logic [3:0] ch_en,
    output logic [3:0] pwm,
    output logic       frame_start,
    output logic [3:0] clamp_flag
);
    cnt_t   cnt_q;
    logic   fs_q, wrap;
    angle_t ang [4];

    assign wrap = cnt_q == cnt_t'(PERIOD_CYC - 1);
    assign ang  = '{angle1, angle2, angle3, angle4};

    // Reset parks the counter at the last count so the first edge after release samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= cnt_t'(PERIOD_CYC - 1);
            fs_q  <= 1'b0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + cnt_t'(1);
            fs_q  <= wrap;
        end
    end

    assign frame_start = fs_q;

    for (genvar g = 0; g < 4; g++) begin : g_ch
        servo_channel #(.MIN_CYC(MIN_CYC), .STEP_CYC(STEP_CYC)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .sample_i (wrap),
            .angle_i  (ang[g]),
            .en_i     (ch_en[g]),
            .cnt_i    (cnt_q),
            .pwm_o    (pwm[g]),
            .clamp_o  (clamp_flag[g])
        );
    end
endmodule

// File: tb/tb_servo_pwm.sv
// tb_servo_pwm: directed checks of frame timing, widths, clamp, mid-frame changes and reset.
module tb_servo_pwm;
    localparam int P  = 500;
    localparam int MN = 40;
    localparam int ST = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] a1, a2, a3, a4, mid_a;
    logic [3:0] ch_en, pwm, cl, cl0;
    logic       fs, cl_var;
    int         n_chk = 0, n_err = 0;
    int         hi [4], rise [4];
    int         fs_n, mid_k = -1;

    always #5 clk = ~clk;

    servo_pwm #(.PERIOD_CYC(P), .MIN_CYC(MN), .STEP_CYC(ST)) dut (
        .clk         (clk),
        .rst         (rst),
        .angle1      (a1),
        .angle2      (a2),
        .angle3      (a3),
        .angle4      (a4),
        .ch_en       (ch_en),
        .pwm         (pwm),
        .frame_start (fs),
        .clamp_flag  (cl)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Measures one full frame starting at the negedge where frame_start is high.
    task automatic grab();
        int t = 0;
        while (fs !== 1'b1 && t < P + 4) begin
            @(negedge clk);
            t++;
        end
        check("fs_seen", fs, 1);
        fs_n   = 0;
        cl0    = cl;
        cl_var = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hi[i]   = 0;
            rise[i] = -1;
        end
        for (int k = 0; k < P; k++) begin
            if (k > 0) @(negedge clk);
            if (k == mid_k) a1 = mid_a;
            fs_n += int'(fs);
            if (cl !== cl0) cl_var = 1'b1;
            for (int i = 0; i < 4; i++)
                if (pwm[i] === 1'b1) begin
                    hi[i]++;
                    if (rise[i] < 0) rise[i] = k;
                end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
`ifdef SERVO_SOFTSTART_EN
        a1 = 8'd100;
`else
        a1 = 8'd0;
`endif
        a2 = 8'd0; a3 = 8'd0; a4 = 8'd0; ch_en = 4'b0001; mid_a = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm, 0);
        check("rst_fs", fs, 0);
        check("rst_cl", cl, 0);
        rst = 1'b1;
        @(negedge clk);
        check("fs_first", fs, 1);
`ifdef SERVO_SOFTSTART_EN
        for (int f = 1; f <= 12; f++) begin
            grab();
            check("soft_w", hi[0], MN + ST * (90 + (f < 10 ? f : 10)));
        end
        check("soft_rise", rise[0], 2);
`else
        grab();
        check("w0_a0", hi[0], MN);
        check("rise0", rise[0], 2);
        check("off_123", hi[1] + hi[2] + hi[3], 0);
        check("fs_once", fs_n, 1);
        check("cl_none", cl0, 0);

        a2 = 8'd180; a3 = 8'd90; ch_en = 4'b0110;
        grab();
        check("w1_a180", hi[1], MN + ST * 180);
        check("w2_a90", hi[2], MN + ST * 90);
        check("rise1", rise[1], 2);
        check("rise2", rise[2], 2);
        check("off_0", hi[0], 0);
        check("off_3", hi[3], 0);

        a4 = 8'd200; ch_en = 4'b1000;
        grab();
        check("w3_clamp", hi[3], MN + ST * 180);
        check("cl_set", cl0, 4'b1000);
        check("cl_hold", cl_var, 0);

        a4 = 8'd170;
        grab();
        check("w3_a170", hi[3], MN + ST * 170);
        check("cl_clear", cl0, 0);

        a1 = 8'd0; ch_en = 4'b0001; mid_k = 250; mid_a = 8'd180;
        grab();
        check("mid_cur", hi[0], MN);
        mid_k = -1;
        grab();
        check("mid_next", hi[0], MN + ST * 180);
        check("mid_rise", rise[0], 2);

        a4 = 8'd200; ch_en = 4'b1001;
        repeat (10) @(negedge clk);
        check("pre_rst_pwm", pwm, 4'b1001);
        check("pre_rst_cl", cl, 4'b1000);
        #1 rst = 1'b0;
        #1;
        check("async_pwm", pwm, 0);
        check("async_cl", cl, 0);
        check("async_fs", fs, 0);
        repeat (2) @(negedge clk);
        check("hold_pwm", pwm, 0);
        rst = 1'b1;
        @(negedge clk);
        check("fs_rerun", fs, 1);
        grab();
        check("post_w0", hi[0], MN + ST * 180);
        check("post_w3", hi[3], MN + ST * 180);
        check("post_rise", rise[0], 2);
        check("post_cl", cl0, 4'b1000);
`endif
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
